// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory slave.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } bus_state_e;

  localparam logic [31:0] BOOT_BASE_DEFAULT = 32'hBFC0_0000;
  localparam int          LANES             = 4;
  localparam int          LANE_W            = 8;
  localparam int          DATA_W            = LANES * LANE_W;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Expand byteenable into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/mips_bus_waitgen.sv
// Wait-state generator: fixed or LFSR-derived stall count, IDLE/WAIT/GRANT FSM.
// Latency: completes in the request cycle when W=0, otherwise after exactly W stall cycles.
// Backpressure: drives waitrequest; aborts if the master drops or changes its request mid-stall.
//
// Ports: clk, reset (async, active-low); req_ok/req_wr/req_addr describe a
// decoded, error-free single-direction request; waitrequest stalls the master;
// complete marks the cycle whose edge performs the access; abort marks a
// stalled request that was withdrawn or altered.
module mips_bus_waitgen
  import mips_bus_pkg::*;
#(
  parameter int          READ_WAIT   = 0,
  parameter int          WRITE_WAIT  = 0,
  parameter bit          RANDOM_WAIT = 1'b0,
  parameter logic [3:0]  RAND_MASK   = 4'h3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_ok,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  output logic        waitrequest,
  output logic        complete,
  output logic        abort
);

  localparam logic [3:0] RD_WAIT = 4'(READ_WAIT);
  localparam logic [3:0] WR_WAIT = 4'(WRITE_WAIT);

  bus_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  wait_val;
  logic        same_req;
  logic        complete_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    waitrequest = 1'b0;
    complete_c  = 1'b0;
    abort       = 1'b0;

    wait_val = RANDOM_WAIT ? (lfsr_q[3:0] & RAND_MASK) : (req_wr ? WR_WAIT : RD_WAIT);
    same_req = req_ok && (req_wr == wr_q) && (req_addr == addr_q);

    case (state_q)
      IDLE: begin
        if (req_ok) begin
          lfsr_d = lfsr_next(lfsr_q);
          if (wait_val == 4'd0) begin
            complete_c = 1'b1;
          end else begin
            // This IDLE cycle is the first stall cycle, so a single wait
            // state goes straight to GRANT; longer ones spend W-1 in WAIT.
            waitrequest = 1'b1;
            cnt_d       = wait_val - 4'd1;
            addr_d      = req_addr;
            wr_d        = req_wr;
            state_d     = (wait_val == 4'd1) ? GRANT : WAIT;
          end
        end
      end
      WAIT: begin
        if (!same_req) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          waitrequest = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = IDLE;
        if (same_req) complete_c = 1'b1;
        else          abort      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // No access may land while reset is held, even though the request is still present.
  assign complete = complete_c && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lfsr_q  <= LFSR_SEED;
      addr_q  <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: rtl/mips_bus_mem.sv
// Word-organised bus memory slave with data and boot windows, byte lanes and error flagging.
// Latency: read data combinational in the completing cycle; stall of W wait states (fixed or random).
// Backpressure: waitrequest high stalls the master; erroneous requests finish in one cycle unstalled.
//
// Ports: clk, reset (async, active-low); address/read/write/byteenable/writedata
// from the CPU; waitrequest, readdata (valid when read && !waitrequest), sticky
// err, and 16-bit wrapping rd_count/wr_count of completed accesses.
module mips_bus_mem
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] DATA_BASE      = 32'h0000_0000,
  parameter int          DATA_WORDS     = 1024,
  parameter logic [31:0] BOOT_BASE      = BOOT_BASE_DEFAULT,
  parameter int          BOOT_WORDS     = 256,
  parameter int          READ_WAIT      = 0,
  parameter int          WRITE_WAIT     = 0,
  parameter bit          RANDOM_WAIT    = 1'b0,
  parameter logic [3:0]  RAND_MASK      = 4'h3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter string       INIT_DATA_FILE = "",
  parameter string       INIT_BOOT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [LANES-1:0]  byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int          DATA_AW    = $clog2(DATA_WORDS);
  localparam int          BOOT_AW    = $clog2(BOOT_WORDS);
  localparam logic [31:0] DATA_BYTES = 32'(DATA_WORDS * 4);
  localparam logic [31:0] BOOT_BYTES = 32'(BOOT_WORDS * 4);

  logic [DATA_W-1:0] data_mem [DATA_WORDS];
  logic [DATA_W-1:0] boot_mem [BOOT_WORDS];

  logic [31:0]        data_off, boot_off;
  logic               in_data, in_boot;
  logic [DATA_AW-1:0] data_idx;
  logic [BOOT_AW-1:0] boot_idx;
  logic               dec_err, req_ok;
  logic               complete, abort;
  logic [DATA_W-1:0]  rd_word;

  // Unsigned offset compare also rejects addresses below each base.
  assign data_off = address - DATA_BASE;
  assign boot_off = address - BOOT_BASE;
  assign in_data  = data_off < DATA_BYTES;
  assign in_boot  = boot_off < BOOT_BYTES;
  assign data_idx = data_off[DATA_AW+1:2];
  assign boot_idx = boot_off[BOOT_AW+1:2];

  assign dec_err = (read || write) &&
                   ((read && write) || (address[1:0] != 2'b00) || (!in_data && !in_boot));
  assign req_ok  = (read || write) && !dec_err;

  mips_bus_waitgen #(
    .READ_WAIT  (READ_WAIT),
    .WRITE_WAIT (WRITE_WAIT),
    .RANDOM_WAIT(RANDOM_WAIT),
    .RAND_MASK  (RAND_MASK),
    .LFSR_SEED  (LFSR_SEED)
  ) u_waitgen (
    .clk        (clk),
    .reset      (reset),
    .req_ok     (req_ok),
    .req_wr     (write),
    .req_addr   (address),
    .waitrequest(waitrequest),
    .complete   (complete),
    .abort      (abort)
  );

  assign rd_word  = in_data ? data_mem[data_idx] : boot_mem[boot_idx];
  assign readdata = (complete && read) ? (rd_word & lane_mask(byteenable)) : '0;

  always_ff @(posedge clk) begin
    if (complete && write) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteenable[i]) begin
          if (in_data) data_mem[data_idx][i*LANE_W +: LANE_W] <= writedata[i*LANE_W +: LANE_W];
          else         boot_mem[boot_idx][i*LANE_W +: LANE_W] <= writedata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  logic        err_q, err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    err_d      = err_q | dec_err | abort;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (complete && read)  rd_count_d = rd_count_q + 16'd1;
    if (complete && write) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q      <= 1'b0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign err      = err_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_bus_mem.sv
// Bench for mips_bus_mem: four instances (zero wait, wait 2, write wait 3, random waits).
// Latency: n/a.
// Backpressure: master holds each request until waitrequest is low.
module tb_mips_bus_mem;

  logic        clk = 1'b0;
  logic        rst_n       [4];
  logic [31:0] address     [4];
  logic        read        [4];
  logic        write       [4];
  logic [3:0]  byteenable  [4];
  logic [31:0] writedata   [4];
  logic        waitrequest [4];
  logic [31:0] readdata    [4];
  logic        err         [4];
  logic [15:0] rd_count    [4];
  logic [15:0] wr_count    [4];

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  mips_bus_mem u_dut0 (
    .clk(clk), .reset(rst_n[0]), .address(address[0]), .read(read[0]), .write(write[0]),
    .byteenable(byteenable[0]), .writedata(writedata[0]), .waitrequest(waitrequest[0]),
    .readdata(readdata[0]), .err(err[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0]));

  mips_bus_mem #(.READ_WAIT(2), .WRITE_WAIT(2)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .address(address[1]), .read(read[1]), .write(write[1]),
    .byteenable(byteenable[1]), .writedata(writedata[1]), .waitrequest(waitrequest[1]),
    .readdata(readdata[1]), .err(err[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1]));

  mips_bus_mem #(.WRITE_WAIT(3)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .address(address[2]), .read(read[2]), .write(write[2]),
    .byteenable(byteenable[2]), .writedata(writedata[2]), .waitrequest(waitrequest[2]),
    .readdata(readdata[2]), .err(err[2]), .rd_count(rd_count[2]), .wr_count(wr_count[2]));

  mips_bus_mem #(.RANDOM_WAIT(1'b1), .RAND_MASK(4'h3), .LFSR_SEED(16'hACE1)) u_dut3 (
    .clk(clk), .reset(rst_n[3]), .address(address[3]), .read(read[3]), .write(write[3]),
    .byteenable(byteenable[3]), .writedata(writedata[3]), .waitrequest(waitrequest[3]),
    .readdata(readdata[3]), .err(err[3]), .rd_count(rd_count[3]), .wr_count(wr_count[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns the stall count and readdata seen in the completing cycle.
  task automatic acc(input int n, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd,
                     output int stalls, output logic [31:0] rdat);
    bit done;
    address[n] = a; read[n] = rd; write[n] = wr; byteenable[n] = be; writedata[n] = wd;
    stalls = 0; rdat = '0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!waitrequest[n]) begin
        rdat = readdata[n];
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout inst=%0d addr=%h observed=stalled expected=grant", n, a);
    end
    @(posedge clk); #1;
    read[n] = 1'b0; write[n] = 1'b0;
  endtask

  task automatic wr_w(input int n, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input int exp_st, input string tag);
    int st; logic [31:0] rdat;
    acc(n, 1'b0, 1'b1, a, be, wd, st, rdat);
    if (exp_st >= 0) check({tag, "_stall"}, 32'(st), 32'(exp_st));
  endtask

  // Expected data goes on the scoreboard at issue and is popped at completion.
  task automatic rd_w(input int n, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] exp, input int exp_st, input string tag);
    int st; logic [31:0] rdat;
    sb.push_back(exp);
    acc(n, 1'b1, 1'b0, a, be, 32'h0, st, rdat);
    check(tag, rdat, sb.pop_front());
    if (exp_st >= 0) check({tag, "_stall"}, 32'(st), 32'(exp_st));
  endtask

  task automatic do_reset(input int n);
    rst_n[n] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n[n] = 1'b1;
  endtask

  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [31:0] pat(input int k);
    return 32'h9E37_79B9 * 32'(k + 1);
  endfunction

  initial begin
    int          st, st_run1[200], exp_st;
    logic [31:0] rdat;
    logic [15:0] m;

    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; address[i] = '0; read[i] = 1'b0; write[i] = 1'b0;
      byteenable[i] = '0; writedata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    check("rst_waitreq", 32'(waitrequest[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_rd_count", 32'(rd_count[0]), 32'd0);
    check("rst_wr_count", 32'(wr_count[0]), 32'd0);
    check("rst_readdata", readdata[0], 32'd0);
    @(posedge clk); #1;

    // Zero-wait instance: basic read/write, lanes, boot window.
    wr_w(0, 32'h4, 4'hF, 32'h5C3A18FC, 0, "w0_word1");
    check("w0_wr_count", 32'(wr_count[0]), 32'd1);
    rd_w(0, 32'h4, 4'hF, 32'h5C3A18FC, 0, "r0_word1");
    check("r0_rd_count", 32'(rd_count[0]), 32'd1);
    rd_w(0, 32'h4, 4'b0101, 32'h003A00FC, 0, "r0_lanes02");
    acc(0, 1'b0, 1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, st, rdat);
    check("w0_be0_readdata", rdat, 32'h0);
    check("w0_be0_count", 32'(wr_count[0]), 32'd2);
    wr_w(0, 32'hBFC0_0000, 4'hF, 32'h8C010004, 0, "w0_boot");
    rd_w(0, 32'hBFC0_0000, 4'hF, 32'h8C010004, 0, "r0_boot");
    check("boot_err_clear", 32'(err[0]), 32'd0);
    rd_w(0, 32'hBFC0_0000 + 32'd1024, 4'hF, 32'h0, 0, "r0_boot_oob");
    check("boot_oob_err", 32'(err[0]), 32'd1);

    do_reset(0);
    acc(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, st, rdat);
    check("rw_both_stall", 32'(st), 32'd0);
    check("rw_both_rdata", rdat, 32'd0);
    check("rw_both_err", 32'(err[0]), 32'd1);
    check("rw_both_rdcnt", 32'(rd_count[0]), 32'd0);
    check("rw_both_wrcnt", 32'(wr_count[0]), 32'd0);
    do_reset(0);
    rd_w(0, 32'h6, 4'hF, 32'h0, 0, "misaligned");
    check("misaligned_err", 32'(err[0]), 32'd1);
    do_reset(0);
    rd_w(0, 32'h4, 4'hF, 32'h5C3A18FC, 0, "mem_kept_over_reset");

    // Two-wait instance: byte write then read-back.
    wr_w(1, 32'h8, 4'hF, 32'h0, 2, "w1_clear");
    wr_w(1, 32'h8, 4'b0010, 32'hAABBCCDD, 2, "w1_byte");
    rd_w(1, 32'h8, 4'hF, 32'h0000CC00, 2, "r1_byte");
    check("w1_counts", {rd_count[1], wr_count[1]}, {16'd1, 16'd2});

    // Write-wait-3 instance: withdrawn write, then reset during WAIT.
    wr_w(2, 32'h20, 4'hF, 32'h11223344, 3, "w2_init");
    address[2] = 32'h20; write[2] = 1'b1; byteenable[2] = 4'hF; writedata[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("ab_stall_idle", 32'(waitrequest[2]), 32'd1);
    @(posedge clk); @(negedge clk);
    check("ab_stall_wait", 32'(waitrequest[2]), 32'd1);
    @(posedge clk); #1 write[2] = 1'b0;
    @(negedge clk);
    check("ab_no_stall", 32'(waitrequest[2]), 32'd0);
    @(posedge clk); #1;
    check("ab_err", 32'(err[2]), 32'd1);
    check("ab_wr_count", 32'(wr_count[2]), 32'd1);
    rd_w(2, 32'h20, 4'hF, 32'h11223344, 0, "ab_mem");

    do_reset(2);
    address[2] = 32'h20; write[2] = 1'b1; byteenable[2] = 4'hF; writedata[2] = 32'hFFFF_FFFF;
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst_n[2] = 1'b0;
    @(posedge clk); #1 write[2] = 1'b0;
    @(posedge clk); #1 rst_n[2] = 1'b1;
    check("rstab_err", 32'(err[2]), 32'd0);
    check("rstab_wr_count", 32'(wr_count[2]), 32'd0);
    rd_w(2, 32'h20, 4'hF, 32'h11223344, 0, "rstab_mem");

    // Random-wait instance: preload, then two identical 200-read runs from the seed.
    for (int k = 0; k < 8; k++) wr_w(3, 32'(k * 4), 4'hF, pat(k), -1, "w3_pre");
    for (int run = 0; run < 2; run++) begin
      do_reset(3);
      m = 16'hACE1;
      for (int i = 0; i < 200; i++) begin
        exp_st = int'(m[3:0] & 4'h3);
        m = model_lfsr(m);
        sb.push_back(pat(i % 8));
        acc(3, 1'b1, 1'b0, 32'((i % 8) * 4), 4'hF, 32'h0, st, rdat);
        check("rand_data", rdat, sb.pop_front());
        check("rand_stall_model", 32'(st), 32'(exp_st));
        check("rand_stall_bound", 32'(st <= 3), 32'd1);
        if (run == 0) st_run1[i] = st;
        else          check("rand_repeat", 32'(st), 32'(st_run1[i]));
      end
      check("rand_rd_count", 32'(rd_count[3]), 32'd200);
      check("rand_err", 32'(err[3]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
